mem_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the single-port `memory` RAM block and is the only agent driving its ports. It accepts one read or write request at a time over a valid/ready handshake, sequences `en`, `mem_write`, `mem_addr` and `mem_write_data` with fixed cycle timing, and returns read data over a second valid/ready handshake. It also keeps wrapping read and write transaction counters for debug.

---
 rtl/mem_ctrl_if.sv | 25 ++
 rtl/mem_ctrl.sv | 106 ++++++++++
 tb/tb_mem_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Request/response handshake bundle between a requester and mem_ctrl.
// The requester uses the master modport; the controller uses the slave modport.
interface mem_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) ();
  logic             req_valid;
  logic             req_ready;
  logic             req_write;
  logic [DEPTH-1:0] req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-outstanding request sequencer in front of a single-port registered-read RAM,
// with wrapping debug counters for completed writes and delivered read responses.
module mem_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  mem_ctrl_if.slave        bus,
  output logic             en,
  output logic             mem_write,
  output logic [DEPTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_write_data,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic             busy,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] rd_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DEPTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic [WIDTH-1:0] rdata_q;
  logic             rsp_valid;
  logic             accept;

  // rst_n gates ready so nothing can be accepted while reset is asserted
  assign bus.req_ready  = (state_q == IDLE) && rst_n;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_rdata  = rdata_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // RAM strobes come from the state register only, never from request inputs
  always_comb begin
    state_d   = state_q;
    en        = 1'b0;
    mem_write = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_d = bus.req_write ? WRITE : READ;
      end
      WRITE: begin
        en        = 1'b1;
        mem_write = 1'b1;
        state_d   = IDLE;
      end
      READ: begin
        en      = 1'b1;
        state_d = WAIT;
      end
      WAIT: state_d = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (bus.rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // RAM read data is valid during WAIT and held in RESP until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rdata_q <= '0;
    else if (state_q == WAIT)  rdata_q <= mem_read_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (state_q == WRITE)                 wr_cnt <= wr_cnt + CNT_W'(1);
      if (state_q == RESP && bus.rsp_ready) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: behavioural RAM, shadow memory and a read-data scoreboard.
// A second instance with 4-bit counters exercises counter wrap.
module tb_mem_ctrl;
  localparam int unsigned WIDTH  = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned CNT_W2 = 4;
  localparam int unsigned WORDS  = 1 << DEPTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  mem_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus2 ();

  logic             en, mem_write, busy;
  logic [DEPTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_write_data;
  logic [WIDTH-1:0] mem_read_data = '0;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;

  logic              en2, mem_write2, busy2;
  logic [DEPTH-1:0]  mem_addr2;
  logic [WIDTH-1:0]  mem_write_data2;
  logic [WIDTH-1:0]  mem_read_data2;
  logic [CNT_W2-1:0] wr_cnt2, rd_cnt2;
  assign mem_read_data2 = '0;

  mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .en(en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt)
  );

  mem_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W2)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .en(en2), .mem_write(mem_write2), .mem_addr(mem_addr2),
    .mem_write_data(mem_write_data2), .mem_read_data(mem_read_data2),
    .busy(busy2), .wr_cnt(wr_cnt2), .rd_cnt(rd_cnt2)
  );

  // Single-port RAM with registered, read-before-write output
  logic [WIDTH-1:0] ram    [WORDS];
  logic [WIDTH-1:0] shadow [WORDS];
  always @(posedge clk) begin
    if (en) begin
      if (mem_write) ram[mem_addr] <= mem_write_data;
      mem_read_data <= ram[mem_addr];
    end
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [WIDTH-1:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  int exp_wr  = 0;
  int exp_rd  = 0;

  // Issue one request at a negedge; returns cycles waited or -1 if never accepted
  task automatic send_req(input logic w, input logic [DEPTH-1:0] a,
                          input logic [WIDTH-1:0] d, output int waited);
    waited = -1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    for (int k = 0; k < 20; k++) begin
      if (bus.req_ready) begin
        waited = k;
        break;
      end
      @(negedge clk);
    end
    if (waited >= 0) begin
      if (w) shadow[a] = d;
      else   exp_q.push_back(shadow[a]);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'h5;
    bus.req_wdata = 8'hFF;
    repeat (3) @(negedge clk);
    n_total++;
    if ({bus.req_ready, en, mem_write, bus.rsp_valid, busy} !== 5'b0)
      $display("FAIL reset_ctrl: got %b required 00000",
               {bus.req_ready, en, mem_write, bus.rsp_valid, busy});
    else n_pass++;
    n_total++;
    if ({mem_addr, mem_write_data, bus.rsp_rdata} !== '0)
      $display("FAIL reset_data: got addr=%h wd=%h rd=%h required 0",
               mem_addr, mem_write_data, bus.rsp_rdata);
    else n_pass++;
    n_total++;
    if ({wr_cnt, rd_cnt} !== '0)
      $display("FAIL reset_cnt: got wr=%0d rd=%0d required 0", wr_cnt, rd_cnt);
    else n_pass++;
    bus.req_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (bus.req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release: got ready=%b busy=%b required 1/0", bus.req_ready, busy);
    else n_pass++;
  endtask

  task automatic test_write_read();
    int c;
    logic [WIDTH-1:0] e;
    send_req(1'b1, 4'h3, 8'hA5, c);
    n_total++;
    if (c < 0 || {en, mem_write, busy} !== 3'b111)
      $display("FAIL wr_strobe: got accept=%0d en/we/busy=%b required 111", c, {en, mem_write, busy});
    else n_pass++;
    @(negedge clk);
    exp_wr++;
    n_total++;
    if ({en, mem_write, bus.req_ready} !== 3'b001 || wr_cnt !== CNT_W'(exp_wr))
      $display("FAIL wr_done: got en/we/ready=%b wr_cnt=%0d required 001 %0d",
               {en, mem_write, bus.req_ready}, wr_cnt, exp_wr);
    else n_pass++;
    send_req(1'b0, 4'h3, 8'h00, c);
    n_total++;
    if (c < 0 || {en, mem_write} !== 2'b10)
      $display("FAIL rd_strobe: got accept=%0d en/we=%b required 10", c, {en, mem_write});
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (bus.rsp_valid !== 1'b0 || en !== 1'b0 || busy !== 1'b1)
      $display("FAIL rd_wait: got valid=%b en=%b busy=%b required 0 0 1", bus.rsp_valid, en, busy);
    else n_pass++;
    @(negedge clk);
    e = exp_q.pop_front();
    n_total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e)
      $display("FAIL rd_data: got valid=%b data=%h required 1 %h", bus.rsp_valid, bus.rsp_rdata, e);
    else n_pass++;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_rd++;
    n_total++;
    if (rd_cnt !== CNT_W'(exp_rd) || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1)
      $display("FAIL rd_done: got rd_cnt=%0d valid=%b ready=%b required %0d 0 1",
               rd_cnt, bus.rsp_valid, bus.req_ready, exp_rd);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DEPTH-1:0] addrs [10];
    int unsigned acc, prev;
    int got;
    logic [WIDTH-1:0] e;
    acc = 0;
    prev = 0;
    for (int i = 0; i < 10; i++) addrs[i] = DEPTH'($urandom_range(0, WORDS - 2));
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.req_addr  = addrs[i];
      bus.req_wdata = WIDTH'($urandom);
      got = -1;
      for (int k = 0; k < 10; k++) begin
        if (bus.req_ready) begin
          got = k;
          break;
        end
        @(negedge clk);
      end
      acc = cyc;
      if (got >= 0) begin
        shadow[bus.req_addr] = bus.req_wdata;
        exp_wr++;
      end
      if (i > 0) begin
        n_total++;
        if (got < 0 || acc - prev != 2)
          $display("FAIL b2b_wr_rate: got interval=%0d required 2", acc - prev);
        else n_pass++;
      end
      prev = acc;
      @(negedge clk);
    end
    bus.req_write = 1'b0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.req_addr = addrs[i];
      got = -1;
      for (int k = 0; k < 10; k++) begin
        if (bus.req_ready) begin
          got = k;
          break;
        end
        @(negedge clk);
      end
      acc = cyc;
      if (got >= 0) exp_q.push_back(shadow[bus.req_addr]);
      if (i > 0) begin
        n_total++;
        if (got < 0 || acc - prev != 4)
          $display("FAIL b2b_rd_rate: got interval=%0d required 4", acc - prev);
        else n_pass++;
      end
      prev = acc;
      @(negedge clk);
      if (i == 9) bus.req_valid = 1'b0;
      got = -1;
      for (int k = 0; k < 10; k++) begin
        if (bus.rsp_valid) begin
          got = k;
          break;
        end
        @(negedge clk);
      end
      n_total++;
      if (got < 0 || exp_q.size() == 0) begin
        $display("FAIL b2b_rsp: got no response for addr %h required one", addrs[i]);
      end else begin
        e = exp_q.pop_front();
        exp_rd++;
        if (bus.rsp_rdata !== e)
          $display("FAIL b2b_rdata: got %h required %h at addr %h", bus.rsp_rdata, e, addrs[i]);
        else n_pass++;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    n_total++;
    if (wr_cnt !== CNT_W'(exp_wr) || rd_cnt !== CNT_W'(exp_rd))
      $display("FAIL b2b_cnt: got wr=%0d rd=%0d required %0d %0d", wr_cnt, rd_cnt, exp_wr, exp_rd);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int c;
    int got;
    logic stable;
    logic [WIDTH-1:0] e;
    send_req(1'b1, 4'hF, 8'h3C, c);
    exp_wr++;
    @(negedge clk);
    send_req(1'b0, 4'hF, 8'h00, c);
    got = -1;
    for (int k = 0; k < 10; k++) begin
      if (bus.rsp_valid) begin
        got = k;
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b1;
    bus.req_write = 1'b1;
    bus.req_addr  = 4'h0;
    bus.req_wdata = ~shadow[0];
    e = (exp_q.size() > 0) ? exp_q[0] : 8'hxx;
    stable = (got >= 0);
    for (int k = 0; k < 5; k++) begin
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e || bus.req_ready !== 1'b0 || busy !== 1'b1)
        stable = 1'b0;
      @(negedge clk);
    end
    n_total++;
    if (!stable || e !== 8'h3C)
      $display("FAIL bp_hold: got valid=%b data=%h ready=%b required 1 3c 0",
               bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
    else n_pass++;
    n_total++;
    if (wr_cnt !== CNT_W'(exp_wr) || ram[0] !== shadow[0])
      $display("FAIL bp_no_accept: got wr=%0d ram0=%h required %0d %h",
               wr_cnt, ram[0], exp_wr, shadow[0]);
    else n_pass++;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    exp_rd++;
    n_total++;
    if (busy !== 1'b0 || bus.req_ready !== 1'b1 || rd_cnt !== CNT_W'(exp_rd))
      $display("FAIL bp_release: got busy=%b ready=%b rd=%0d required 0 1 %0d",
               busy, bus.req_ready, rd_cnt, exp_rd);
    else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int c;
    logic seen;
    logic same;
    send_req(1'b0, 4'h3, 8'h00, c);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    n_total++;
    if (busy !== 1'b1 || en !== 1'b0 || bus.rsp_valid !== 1'b0)
      $display("FAIL mid_wait: got busy=%b en=%b valid=%b required 1 0 0", busy, en, bus.rsp_valid);
    else n_pass++;
    rst_n = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    #1;
    n_total++;
    if ({busy, bus.rsp_valid, bus.req_ready} !== 3'b000 || {wr_cnt, rd_cnt} !== '0)
      $display("FAIL mid_async: got busy/valid/ready=%b wr=%0d rd=%0d required 000 0 0",
               {busy, bus.rsp_valid, bus.req_ready}, wr_cnt, rd_cnt);
    else n_pass++;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_total++;
    if (seen || rd_cnt !== '0 || bus.req_ready !== 1'b1)
      $display("FAIL mid_no_rsp: got seen=%b rd=%0d ready=%b required 0 0 1", seen, rd_cnt, bus.req_ready);
    else n_pass++;
    same = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) if (ram[i] !== shadow[i]) same = 1'b0;
    n_total++;
    if (!same) $display("FAIL mid_ram: got ram differs from written contents required unchanged");
    else n_pass++;
  endtask

  task automatic test_counter_wrap();
    int got;
    bus2.req_valid = 1'b1;
    bus2.req_write = 1'b1;
    for (int i = 0; i < 17; i++) begin
      bus2.req_addr  = DEPTH'(i);
      bus2.req_wdata = WIDTH'(i);
      got = -1;
      for (int k = 0; k < 10; k++) begin
        if (bus2.req_ready) begin
          got = k;
          break;
        end
        @(negedge clk);
      end
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if (got < 0 || wr_cnt2 !== CNT_W2'(i + 1))
        $display("FAIL wrap_wr_cnt: got %0d required %0d after write %0d", wr_cnt2, (i + 1) % 16, i);
      else n_pass++;
    end
    bus2.req_valid = 1'b0;
    n_total++;
    if (rd_cnt2 !== '0)
      $display("FAIL wrap_rd_cnt: got %0d required 0", rd_cnt2);
    else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;
    bus2.req_valid = 1'b0;
    bus2.req_write = 1'b0;
    bus2.req_addr  = '0;
    bus2.req_wdata = '0;
    bus2.rsp_ready = 1'b0;
    for (int i = 0; i < int'(WORDS); i++) begin
      ram[i]    = WIDTH'(i * 17);
      shadow[i] = WIDTH'(i * 17);
    end
    @(negedge clk);
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_read();
    test_counter_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
